// File: rtl/axi_hp_read_checker_if.sv
// AXI3 HP read-only channel bundle (AR + R) between the checker and the HP port.
interface axi_hp_read_checker_if;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [5:0]  arid;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arlen, arsize, arburst, arcache, arid, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arcache, arid, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_hp_read_checker.sv
// Reads back the HP generator window in 16-beat INCR bursts, checks each beat against
// the test pattern and reports data/protocol error counts and RUN cycle count.
module axi_hp_read_checker #(
    parameter logic [13:0] ADDR_HI = 14'h3FFF,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [10:0]           burst_num,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic                  first_err_valid,
    output logic [15:0]           first_err_beat,
    output logic [7:0]            proto_err_cnt,
    output logic [31:0]           time_cnt,
    axi_hp_read_checker_if.master axi
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [10:0] burst_q;
    logic [11:0] ar_issued;
    logic [11:0] bursts_done;
    logic [3:0]  outstanding;
    logic [3:0]  burst_beat;
    logic [17:0] offset;
    logic [15:0] beat_n;
    logic        in_run, ar_fire, beat_acc, rlast_acc, last_burst;
    logic        mismatch, resp_bad, last_bad;
    logic [63:0] exp_data;
    logic [1:0]  proto_inc;
    logic [8:0]  proto_sum;

    assign in_run = (state_q == RUN);
    assign busy   = in_run;
    assign done   = (state_q == DONE);

    assign axi.araddr  = {ADDR_HI, offset};
    assign axi.arlen   = 4'hF;
    assign axi.arsize  = 3'b011;
    assign axi.arburst = 2'b01;
    assign axi.arcache = 4'b0010;
    assign axi.arid    = '0;
    // Only handshakes or state change can drop arvalid, so address is never retracted.
    assign axi.arvalid = in_run && (ar_issued <= {1'b0, burst_q}) && (outstanding < 4'(MAX_OUT));
    assign axi.rready  = in_run;

    assign ar_fire    = axi.arvalid && axi.arready;
    assign beat_acc   = in_run && axi.rvalid;
    assign rlast_acc  = beat_acc && axi.rlast;
    assign last_burst = rlast_acc && (bursts_done == {1'b0, burst_q});

    assign exp_data  = {8'hA0, beat_n, 8'h0A, 8'hB0, beat_n, 8'h0B};
    assign mismatch  = (axi.rdata != exp_data);
    assign resp_bad  = (axi.rresp != 2'b00);
    assign last_bad  = (axi.rlast != (burst_beat == 4'hF));
    assign proto_inc = {1'b0, resp_bad} + {1'b0, last_bad};
    assign proto_sum = {1'b0, proto_err_cnt} + {7'b0, proto_inc};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (last_burst) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q         <= '0;
            ar_issued       <= '0;
            bursts_done     <= '0;
            outstanding     <= '0;
            burst_beat      <= '0;
            offset          <= '0;
            beat_n          <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_beat  <= '0;
            proto_err_cnt   <= '0;
            time_cnt        <= '0;
        end else if (!in_run) begin
            if (start) begin
                burst_q         <= burst_num;
                ar_issued       <= '0;
                bursts_done     <= '0;
                outstanding     <= '0;
                burst_beat      <= '0;
                offset          <= '0;
                beat_n          <= '0;
                err_cnt         <= '0;
                first_err_valid <= 1'b0;
                first_err_beat  <= '0;
                proto_err_cnt   <= '0;
                time_cnt        <= '0;
            end
        end else begin
            time_cnt <= time_cnt + 32'd1;
            if (ar_fire) begin
                offset    <= offset + 18'd128;
                ar_issued <= ar_issued + 12'd1;
            end
            if (ar_fire && !rlast_acc)
                outstanding <= outstanding + 4'd1;
            else if (!ar_fire && rlast_acc && outstanding != '0)
                outstanding <= outstanding - 4'd1;
            if (beat_acc) begin
                beat_n     <= beat_n + 16'd1;
                // Burst position is modulo 16 regardless of where rlast actually appeared.
                burst_beat <= burst_beat + 4'd1;
                if (axi.rlast) bursts_done <= bursts_done + 12'd1;
                if (mismatch) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_beat  <= beat_n;
                    end
                end
                proto_err_cnt <= proto_sum[8] ? 8'hFF : proto_sum[7:0];
            end
        end
    end
endmodule

// File: tb/tb_axi_hp_read_checker.sv
// Bench for axi_hp_read_checker: memory-slave model with configurable faults and a
// beat-level reference of the expected counters.
module tb_axi_hp_read_checker;
    localparam int          MAXB = 32768;
    localparam int          MAXO = 4;
    localparam logic [13:0] AHI  = 14'h3FFF;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [10:0] burst_num;
    logic        busy, done, first_err_valid;
    logic [15:0] err_cnt, first_err_beat;
    logic [7:0]  proto_err_cnt;
    logic [31:0] time_cnt;

    axi_hp_read_checker_if axi();

    axi_hp_read_checker #(.ADDR_HI(AHI), .MAX_OUT(MAXO)) dut (
        .clk(clk), .reset(reset), .start(start), .burst_num(burst_num),
        .busy(busy), .done(done), .err_cnt(err_cnt),
        .first_err_valid(first_err_valid), .first_err_beat(first_err_beat),
        .proto_err_cnt(proto_err_cnt), .time_cnt(time_cnt), .axi(axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Slave configuration / fault masks
    bit   corrupt [MAXB];
    bit   rbad    [MAXB];
    bit   flip    [MAXB];
    int   fire_cyc[MAXB];
    logic [31:0] ar_log[$];
    int   pending, sbeat, bret, ar_stall_left;
    int   ar_pct = 100;
    int   rv_pct = 100;
    bit   chk_out = 1'b1;
    int   start_cyc;

    function automatic logic [63:0] pat(input int n);
        logic [15:0] b;
        b = 16'(n);
        return {8'hA0, b, 8'h0A, 8'hB0, b, 8'h0B};
    endfunction

    initial begin
        bit af, rf, prev_wait, prev_rst;
        logic [31:0] aaddr, prev_addr;
        prev_wait = 1'b0; prev_rst = 1'b0; prev_addr = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
        pending = 0; sbeat = 0; bret = 0; ar_stall_left = 0;
        forever begin
            @(negedge clk);
            af    = axi.arvalid && axi.arready;
            rf    = axi.rvalid && axi.rready;
            aaddr = axi.araddr;
            if (prev_wait && !prev_rst) begin
                chk("arvalid_hold", axi.arvalid, 1);
                chk("araddr_hold", axi.araddr, prev_addr);
            end
            prev_wait = axi.arvalid && !axi.arready;
            prev_addr = axi.araddr;
            prev_rst  = reset;
            @(posedge clk); #1;
            if (af) begin
                ar_log.push_back(aaddr);
                pending++;
            end
            if (rf) begin
                fire_cyc[sbeat] = cyc;
                if ((sbeat % 16) == 15) begin
                    pending--;
                    bret++;
                end
                sbeat++;
            end
            if (af && chk_out) chk("max_outstanding", ((ar_log.size() - bret) <= MAXO), 1);
            axi.arready = (ar_stall_left > 0) ? 1'b0 : (int'($urandom_range(99)) < ar_pct);
            if (ar_stall_left > 0) ar_stall_left--;
            if (pending > 0 && sbeat < MAXB && int'($urandom_range(99)) < rv_pct) begin
                axi.rvalid = 1'b1;
                axi.rdata  = corrupt[sbeat] ? (pat(sbeat) ^ 64'h0000_0100_0000_0000) : pat(sbeat);
                axi.rresp  = rbad[sbeat] ? 2'b10 : 2'b00;
                axi.rlast  = ((sbeat % 16) == 15) ^ flip[sbeat];
            end else begin
                axi.rvalid = 1'b0;
                axi.rdata  = '0;
                axi.rresp  = 2'b00;
                axi.rlast  = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "global timeout");
    end

    typedef struct {
        int bn, ar_stall, ar_pct, rv_pct, c0, c1, resp_beat, flip_beat;
        bit all_bad, mid;
        int e_err, e_fv, e_first, e_proto, e_ars;
    } vec_t;

    vec_t rows[5];

    task automatic clear_masks();
        for (int i = 0; i < MAXB; i++) begin
            corrupt[i] = 1'b0; rbad[i] = 1'b0; flip[i] = 1'b0;
        end
    endtask

    // Reference: walk beats in arrival order until the required number of rlast beats.
    task automatic model(input int n, output int e_err, output int e_fv, output int e_first,
                         output int e_proto, output int e_stop);
        int  rl;
        bit  lst;
        rl = 0; e_err = 0; e_fv = 0; e_first = 0; e_proto = 0; e_stop = MAXB - 1;
        for (int i = 0; i < MAXB; i++) begin
            lst = ((i % 16) == 15) ^ flip[i];
            if (corrupt[i]) begin
                if (e_fv == 0) begin e_fv = 1; e_first = i; end
                e_err++;
            end
            e_proto += int'(rbad[i]) + int'(flip[i]);
            if (lst) begin
                rl++;
                if (rl == n) begin e_stop = i; break; end
            end
        end
        if (e_err > 65535) e_err = 65535;
        if (e_proto > 255) e_proto = 255;
    endtask

    task automatic do_start(input int bn, input int stall);
        pending = 0; sbeat = 0; bret = 0; ar_log.delete();
        ar_stall_left = stall;
        start = 1'b1; burst_num = 11'(bn);
        @(posedge clk); #2;
        start = 1'b0;
        start_cyc = cyc;
        chk("entry_busy", busy, 1);
        chk("entry_done", done, 0);
        chk("entry_err_cnt", err_cnt, 0);
        chk("entry_first_valid", first_err_valid, 0);
        chk("entry_proto", proto_err_cnt, 0);
        chk("entry_time", time_cnt, 0);
    endtask

    task automatic recover();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit from_model);
        int bound, m_err, m_fv, m_first, m_proto, m_stop, bad_k;
        bit ok;
        logic [31:0] exp_a, got_a;
        if (!from_model) begin
            clear_masks();
            if (v.all_bad)
                for (int i = 0; i < MAXB; i++) begin corrupt[i] = 1'b1; rbad[i] = 1'b1; end
            if (v.c0 >= 0) corrupt[v.c0] = 1'b1;
            if (v.c1 >= 0) corrupt[v.c1] = 1'b1;
            if (v.resp_beat >= 0) rbad[v.resp_beat] = 1'b1;
            if (v.flip_beat >= 0) flip[v.flip_beat] = 1'b1;
        end
        ar_pct = v.ar_pct; rv_pct = v.rv_pct; chk_out = (v.flip_beat < 0);
        bound = (v.bn + 1) * 16 * 200 / v.rv_pct + v.ar_stall + 500;
        do_start(v.bn, v.ar_stall);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (v.mid && k == 5) begin start = 1'b1; burst_num = 11'(v.bn + 7); end
            if (done) begin ok = 1'b1; break; end
        end
        start = 1'b0;
        chk("run_completes", ok, 1);
        if (!ok) begin
            recover();
            return;
        end
        model(v.bn + 1, m_err, m_fv, m_first, m_proto, m_stop);
        chk("done", done, 1);
        chk("busy", busy, 0);
        chk("arvalid_done", axi.arvalid, 0);
        chk("rready_done", axi.rready, 0);
        chk("err_cnt", err_cnt, from_model ? m_err : v.e_err);
        chk("first_err_valid", first_err_valid, from_model ? m_fv : v.e_fv);
        chk("first_err_beat", first_err_beat, from_model ? m_first : v.e_first);
        chk("proto_err_cnt", proto_err_cnt, from_model ? m_proto : v.e_proto);
        chk("time_cnt", time_cnt, fire_cyc[m_stop] - start_cyc);
        chk("ar_count", ar_log.size(), v.e_ars);
        bad_k = -1;
        for (int k = 0; k < ar_log.size(); k++)
            if (bad_k < 0 && ar_log[k] != {AHI, 18'(k * 128)}) bad_k = k;
        if (bad_k < 0) bad_k = ar_log.size() - 1;
        if (bad_k >= 0) begin
            exp_a = {AHI, 18'(bad_k * 128)};
            got_a = ar_log[bad_k];
            chk("araddr_seq", got_a, exp_a);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_first_valid", first_err_valid, 0);
        chk("rst_first_beat", first_err_beat, 0);
        chk("rst_proto", proto_err_cnt, 0);
        chk("rst_time", time_cnt, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_araddr", axi.araddr, 32'hFFFC_0000);
    endtask

    initial begin
        vec_t rv;
        bit   ok;
        //            bn  stall arp rvp  c0  c1 resp flip bad mid  err   fv first proto ars
        rows[0] = '{   0,   0, 100, 100, -1, -1, -1, -1, 0, 0,     0, 0,  0,   0,    1};
        rows[1] = '{   3,   0, 100, 100, 20, 40, -1, -1, 0, 1,     2, 1, 20,   0,    4};
        rows[2] = '{   9,  10, 100,  40, -1, -1, -1, -1, 0, 0,     0, 0,  0,   0,   10};
        rows[3] = '{   2,   0, 100, 100, -1, -1,  3,  7, 0, 0,     0, 0,  0,   2,    3};
        rows[4] = '{2047,   0, 100, 100, -1, -1, -1, -1, 1, 0, 32768, 1,  0, 255, 2048};

        reset = 1'b1; start = 1'b0; burst_num = '0;
        clear_masks();
        repeat (3) @(posedge clk);
        #2 chk_reset_vals();
        reset = 1'b0;
        @(posedge clk); #2;

        for (int r = 0; r < 5; r++) run_vec(rows[r], 1'b0);

        // Reset in the middle of an 8-burst run, then a clean restart
        clear_masks();
        ar_pct = 100; rv_pct = 60; chk_out = 1'b1;
        do_start(7, 0);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #2;
            if (bret >= 2) begin ok = 1'b1; break; end
        end
        chk("two_bursts_before_reset", ok, 1);
        reset = 1'b1;
        @(posedge clk); #2;
        chk_reset_vals();
        reset = 1'b0;
        @(posedge clk); #2;
        run_vec('{1, 0, 100, 100, -1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 2}, 1'b0);

        // Random traffic and faults against the reference
        for (int t = 0; t < 8; t++) begin
            rv = '{0, 0, 100, 100, -1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0};
            rv.bn       = int'($urandom_range(7));
            rv.ar_stall = int'($urandom_range(5));
            rv.ar_pct   = 40 + int'($urandom_range(60));
            rv.rv_pct   = 30 + int'($urandom_range(70));
            rv.e_ars    = rv.bn + 1;
            clear_masks();
            for (int i = 0; i < (rv.bn + 1) * 16; i++) begin
                corrupt[i] = ($urandom_range(9) == 0);
                rbad[i]    = ($urandom_range(19) == 0);
            end
            run_vec(rv, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
